async_fifo_wr_flag_gen: RTL and testbench
=========================================

# async_fifo_wr_flag_gen

Write-side status block of the async FIFO, directly downstream of the write-domain wrapping address counter. Consumes the counter's (ADDR_WIDTH+1)-bit binary pointer and converts it to a registered Gray code for the read domain. Synchronizes the read domain's Gray pointer into clk_i. Produces the full flag fed back to the counter's count-forbid input, plus an advisory fill level and almost-full flag.

## Interface
- ADDR_WIDTH, 7: address bits; FIFO depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits; legal range 1..15.
- SYNC_STAGES, 2: flops in the read-pointer synchronizer; legal 2..4.
- AF_MARGIN, 4: almost-full asserts when free slots <= AF_MARGIN; legal 0..2^ADDR_WIDTH-1.
- clk_i  in  1  write-domain clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- wr_ptr_i  in  ADDR_WIDTH+1  binary write pointer from the write counter, registered in clk_i.
- rd_gray_i  in  ADDR_WIDTH+1  read pointer in Gray code, registered in the read clock domain, asynchronous to clk_i.
- wr_gray_o  out  ADDR_WIDTH+1  registered Gray code of wr_ptr_i, crossed to the read domain.
- full_o  out  1  FIFO full; drives the counter's forbid input.
- wr_level_o  out  ADDR_WIDTH+1  registered occupancy seen from the write side, 0..2^ADDR_WIDTH.
- almost_full_o  out  1  registered; free slots <= AF_MARGIN.

## Operation
- Gray encode: wr_gray_o <= wr_ptr_i ^ (wr_ptr_i >> 1) on every clk_i edge. No other logic drives wr_gray_o; no combinational path from wr_ptr_i to wr_gray_o.
- Synchronizer: a SYNC_STAGES-deep flop chain on rd_gray_i. Its last stage is rd_gray_s.
  - No logic sits between the chain stages.
  - rd_gray_i is consumed only by the first stage.
- Gray decode: rd_bin_s[ADDR_WIDTH] = rd_gray_s[ADDR_WIDTH]; rd_bin_s[i] = rd_bin_s[i+1] ^ rd_gray_s[i]. Purely combinational.
- Full: full_o = (wr_ptr_i[ADDR_WIDTH] != rd_bin_s[ADDR_WIDTH]) && (wr_ptr_i[ADDR_WIDTH-1:0] == rd_bin_s[ADDR_WIDTH-1:0]).
  - Combinational from flop outputs only (wr_ptr_i and rd_gray_s).
  - Zero cycles from a write pointer increment to full_o. This is mandatory so that the forbid input stops the next write.
- Level: diff = (wr_ptr_i - rd_bin_s), modulo 2^(ADDR_WIDTH+1), in ADDR_WIDTH+1 bits. wr_level_o <= diff.
- Almost-full: almost_full_o <= (2^ADDR_WIDTH - diff) <= AF_MARGIN. Computed at ADDR_WIDTH+2 bits to avoid overflow.
- Pessimism: level is an overestimate by up to SYNC_STAGES+1 read-side updates. full_o may remain asserted after reads until those reads propagate. The flag is never optimistic.
- Wrap-around: pointers wrap at 2^(ADDR_WIDTH+1) with no special handling. The MSB difference alone distinguishes full from empty.

## Timing
- Reset values: wr_gray_o=0, all synchronizer stages=0, wr_level_o=0, almost_full_o=0. full_o evaluates to 0 because both pointers are 0.
- Reset is asynchronous and may occur mid-operation. All flops clear immediately. The read domain must be reset in the same event; otherwise the behaviour is undefined.
- wr_ptr_i -> wr_gray_o: 1 cycle.
- wr_ptr_i -> full_o: 0 cycles.
- wr_ptr_i -> wr_level_o / almost_full_o: 1 cycle.
- rd_gray_i change -> full_o deassert: SYNC_STAGES clk_i edges.
- rd_gray_i change -> wr_level_o: SYNC_STAGES+1 edges.
- rd_gray_i must change at most one bit per read-clock edge (Gray property). Any value sampled mid-transition resolves to the old or the new pointer.

## Configuration
- Macro ASYNC_FIFO_WR_LEVEL_EN.
- Defined: the level subtractor, wr_level_o register and almost_full_o register are compiled in, as described above.
- Undefined: that logic is omitted. wr_level_o and almost_full_o are tied to constant 0. full_o, wr_gray_o and the synchronizer are unchanged. AF_MARGIN is ignored.

## Test plan
- Reset: hold rst_n_i=0 with wr_ptr_i=5 and rd_gray_i=3. Required: all outputs 0. After release, wr_gray_o=7 (Gray of 5) one edge later.
- Fill to full (ADDR_WIDTH=3, rd_gray_i=0): step wr_ptr_i 0..8.
  - full_o=1 in the same cycle wr_ptr_i=8; full_o=0 for 0..7.
  - wr_level_o=8 one cycle later.
  - almost_full_o=1 from wr_ptr_i=4 (AF_MARGIN=4).
- Drain release: at wr_ptr_i=8, set rd_gray_i=1. Required: full_o drops exactly SYNC_STAGES edges later; wr_level_o=7 one edge after that.
- Wrap: wr_ptr_i=15 with rd pointer 7 (Gray 4) -> full_o=1. wr_ptr_i=0 with rd pointer 8 (Gray 12) -> full_o=1. wr_ptr_i=0 with rd pointer 0 -> full_o=0.
- Gray stream: sweep wr_ptr_i through all 2^(ADDR_WIDTH+1) values in sequence. Required: wr_gray_o changes exactly one bit per step, including the wrap from 15 to 0.
- With ASYNC_FIFO_WR_LEVEL_EN undefined, rerun the fill scenario. Required: identical full_o and wr_gray_o; wr_level_o=0 and almost_full_o=0 throughout.

Source files
------------

// File: rtl/async_fifo_wr_flag_gen.sv
// ---------------------------------------------------------------------------
// async_fifo_wr_flag_gen
//   Write-side status block of the async FIFO. Gray-encodes the write pointer
//   for the read domain, synchronizes the read domain's Gray pointer into
//   clk_i, and derives the full flag (fed back to the write counter's forbid
//   input) plus an advisory fill level and almost-full flag.
//
//   Optional feature macro: ASYNC_FIFO_WR_LEVEL_EN
//     defined   : wr_level_o / almost_full_o are live registered outputs
//     undefined : level logic is omitted, both outputs tie to 0
//
// Parameters
//   ADDR_WIDTH  : address bits, depth = 2**ADDR_WIDTH (1..15)
//   SYNC_STAGES : read-pointer synchronizer depth (2..4)
//   AF_MARGIN   : almost-full when free slots <= AF_MARGIN
//
// Ports
//   clk_i         in   write-domain clock
//   rst_n_i       in   asynchronous active-low reset
//   wr_ptr_i      in   binary write pointer (ADDR_WIDTH+1), registered upstream
//   rd_gray_i     in   read pointer, Gray code, from the read clock domain
//   wr_gray_o     out  registered Gray code of wr_ptr_i
//   full_o        out  FIFO full (combinational from flops only)
//   wr_level_o    out  registered occupancy seen from the write side
//   almost_full_o out  registered, free slots <= AF_MARGIN
// ---------------------------------------------------------------------------
module async_fifo_wr_flag_gen #(
    parameter int ADDR_WIDTH  = 7,
    parameter int SYNC_STAGES = 2,
    parameter int AF_MARGIN   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [ADDR_WIDTH:0]   wr_ptr_i,
    input  logic [ADDR_WIDTH:0]   rd_gray_i,
    output logic [ADDR_WIDTH:0]   wr_gray_o,
    output logic                  full_o,
    output logic [ADDR_WIDTH:0]   wr_level_o,
    output logic                  almost_full_o
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0]                   r_wr_gray;
    logic [SYNC_STAGES-1:0][PW-1:0]  r_rd_gray_sync;
    logic [PW-1:0]                   w_rd_gray_s;
    logic [PW-1:0]                   w_rd_bin;

    // Gray encode straight into a flop so the read domain only ever sees a
    // glitch-free, single-bit-change value.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_wr_gray <= '0;
        else          r_wr_gray <= wr_ptr_i ^ (wr_ptr_i >> 1);
    end

    assign wr_gray_o = r_wr_gray;

    // Plain flop chain; nothing between stages, rd_gray_i feeds stage 0 only.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rd_gray_sync <= '0;
        end else begin
            r_rd_gray_sync[0] <= rd_gray_i;
            for (int i = 1; i < SYNC_STAGES; i++)
                r_rd_gray_sync[i] <= r_rd_gray_sync[i-1];
        end
    end

    assign w_rd_gray_s = r_rd_gray_sync[SYNC_STAGES-1];

    // Gray -> binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_rd_bin = '0;
        for (int i = 0; i < PW; i++)
            w_rd_bin[i] = ^(w_rd_gray_s >> i);
    end

    // Full: MSBs differ, address bits match. Zero-cycle path from wr_ptr_i so
    // the counter's forbid stops the very next write.
    assign full_o = (wr_ptr_i[ADDR_WIDTH] != w_rd_bin[ADDR_WIDTH]) &&
                    (wr_ptr_i[ADDR_WIDTH-1:0] == w_rd_bin[ADDR_WIDTH-1:0]);

`ifdef ASYNC_FIFO_WR_LEVEL_EN
    localparam logic [PW:0] DEPTH_W = (PW+1)'(1) << ADDR_WIDTH;
    localparam logic [PW:0] AF_W    = (PW+1)'(AF_MARGIN);

    logic [PW-1:0] w_diff;
    logic [PW:0]   w_free;
    logic [PW-1:0] r_wr_level;
    logic          r_almost_full;

    // Modular difference handles pointer wrap without special cases; the
    // stale synchronized read pointer makes this a safe overestimate.
    assign w_diff = wr_ptr_i - w_rd_bin;
    assign w_free = DEPTH_W - {1'b0, w_diff};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_level    <= '0;
            r_almost_full <= 1'b0;
        end else begin
            r_wr_level    <= w_diff;
            r_almost_full <= (w_free <= AF_W);
        end
    end

    assign wr_level_o    = r_wr_level;
    assign almost_full_o = r_almost_full;
`else
    assign wr_level_o    = '0;
    assign almost_full_o = 1'b0;
`endif

endmodule

// File: tb/tb_async_fifo_wr_flag_gen.sv
module tb_async_fifo_wr_flag_gen;

    localparam int AW    = 3;
    localparam int SS    = 2;
    localparam int AFM   = 4;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;
`ifdef ASYNC_FIFO_WR_LEVEL_EN
    localparam bit LVL_EN = 1'b1;
`else
    localparam bit LVL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [PW-1:0] wr_ptr = '0;
    logic [PW-1:0] rd_ptr_b = '0;     // read pointer in binary; DUT sees its Gray code
    logic [PW-1:0] rd_gray;
    logic [PW-1:0] wr_gray_o;
    logic          full_o;
    logic [PW-1:0] wr_level_o;
    logic          almost_full_o;

    int n_chk  = 0;
    int n_fail = 0;

    assign rd_gray = rd_ptr_b ^ (rd_ptr_b >> 1);

    always #5 clk = ~clk;

    async_fifo_wr_flag_gen #(.ADDR_WIDTH(AW), .SYNC_STAGES(SS), .AF_MARGIN(AFM)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .wr_ptr_i     (wr_ptr),
        .rd_gray_i    (rd_gray),
        .wr_gray_o    (wr_gray_o),
        .full_o       (full_o),
        .wr_level_o   (wr_level_o),
        .almost_full_o(almost_full_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The write side sees the read pointer as it was SS write edges ago; the
    // queue holds the last SS read pointers, oldest first.
    logic [PW-1:0] m_q[$];
    logic [PW-1:0] m_gray  = '0;
    logic [PW-1:0] m_level = '0;
    logic          m_af    = 1'b0;

    function automatic logic [PW-1:0] m_sync();
        return (m_q.size() != 0) ? m_q[0] : '0;
    endfunction

    function automatic int occ_now();
        logic [PW-1:0] d;
        d = wr_ptr - m_sync();
        return int'(d);
    endfunction

    function automatic logic exp_full();
        return occ_now() == DEPTH;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            for (int i = 0; i < SS; i++) m_q.push_back('0);
            m_gray  = '0;
            m_level = '0;
            m_af    = 1'b0;
        end else begin
            int occ;
            int fr;
            occ = occ_now();
            fr  = DEPTH - occ;
            if (fr < 0) fr += (1 << (PW + 1));
            m_level = PW'(occ);
            m_af    = (fr <= AFM);
            m_gray  = wr_ptr ^ (wr_ptr >> 1);
            m_q.push_back(rd_ptr_b);
            void'(m_q.pop_front());
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("cyc_gray",  32'(wr_gray_o),     32'(m_gray));
        chk("cyc_full",  32'(full_o),        32'(exp_full()));
        chk("cyc_level", 32'(wr_level_o),    LVL_EN ? 32'(m_level) : 32'd0);
        chk("cyc_af",    32'(almost_full_o), LVL_EN ? 32'(m_af)    : 32'd0);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset both domains together, away from the clock edge.
    task automatic do_reset();
        rst_n    = 1'b0;
        wr_ptr   = '0;
        rd_ptr_b = '0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [PW-1:0] prev;
        bit            wr_bias;

        // Reset with nonzero inputs: everything registered must read 0.
        wr_ptr   = 4'd5;
        rd_ptr_b = 4'd2;              // Gray 3
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_gray",  32'(wr_gray_o),     0);
        chk("rst_full",  32'(full_o),        0);
        chk("rst_level", 32'(wr_level_o),    0);
        chk("rst_af",    32'(almost_full_o), 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("rel_gray7", 32'(wr_gray_o), 7);

        // Fill to full with the read pointer parked at 0.
        tick();
        do_reset();
        for (int k = 0; k <= DEPTH; k++) begin
            wr_ptr = PW'(k);
            #1;
            chk("fill_full", 32'(full_o), (k == DEPTH) ? 1 : 0);
            if (k >= 1) begin
                chk("fill_level", 32'(wr_level_o),    LVL_EN ? 32'(k - 1) : 0);
                chk("fill_af",    32'(almost_full_o), (LVL_EN && (k - 1) >= 4) ? 1 : 0);
            end
            tick();
        end
        chk("full_level8", 32'(wr_level_o),    LVL_EN ? 8 : 0);
        chk("full_af",     32'(almost_full_o), LVL_EN ? 1 : 0);
        chk("full_hold",   32'(full_o),        1);

        // One read: full releases exactly SS edges later, level one after.
        rd_ptr_b = 4'd1;
        for (int s = 1; s <= SS; s++) begin
            tick();
            chk("drain_full", 32'(full_o), (s < SS) ? 1 : 0);
        end
        tick();
        chk("drain_level7", 32'(wr_level_o), LVL_EN ? 7 : 0);

        // Wrap-around cases.
        do_reset();
        wr_ptr = 4'd15; rd_ptr_b = 4'd7;
        repeat (SS) tick();
        chk("wrap_15_7", 32'(full_o), 1);
        wr_ptr = 4'd0; rd_ptr_b = 4'd8;
        repeat (SS) tick();
        chk("wrap_0_8", 32'(full_o), 1);
        rd_ptr_b = 4'd0;
        repeat (SS) tick();
        chk("wrap_0_0", 32'(full_o), 0);

        // Gray stream: one bit change per step, including the wrap to 0.
        do_reset();
        tick();
        prev = wr_gray_o;
        for (int k = 1; k <= (1 << PW); k++) begin
            wr_ptr = PW'(k);
            tick();
            chk("gray_onebit", 32'($countones(wr_gray_o ^ prev)), 1);
            prev = wr_gray_o;
        end
        chk("gray_wrap0", 32'(wr_gray_o), 0);

        // Randomised traffic with a legal writer (stops on full) and reader
        // (never passes the write pointer), plus one mid-cycle reset.
        do_reset();
        wr_bias = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            if (n % 200 == 0) wr_bias = ~wr_bias;
            if ($urandom_range(0, 3) < (wr_bias ? 3 : 1) && !exp_full())
                wr_ptr = wr_ptr + 1'b1;
            if ($urandom_range(0, 3) < (wr_bias ? 1 : 3) && rd_ptr_b != wr_ptr)
                rd_ptr_b = rd_ptr_b + 1'b1;
            if (n == 777) begin
                #2;
                rst_n = 1'b0; wr_ptr = '0; rd_ptr_b = '0;
                #1;
                chk("mid_rst_gray",  32'(wr_gray_o),     0);
                chk("mid_rst_full",  32'(full_o),        0);
                chk("mid_rst_level", 32'(wr_level_o),    0);
                chk("mid_rst_af",    32'(almost_full_o), 0);
                #1 rst_n = 1'b1;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
